// File: rtl/exec_controller_pkg.sv
// Shared definitions for the execution controller: debug command codes,
// FSM state encoding and a small state-decode helper.
package exec_controller_pkg;

    // Command codes presented on i_cmd by the debug unit.
    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_RUN   = 2'b01,
        CMD_STEP  = 2'b10,
        CMD_ABORT = 2'b11
    } cmd_e;

    // Controller states. DONE is terminal until reset.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        DONE = 2'b11
    } state_e;

    // The pipeline is enabled exactly while executing (RUN or STEP).
    function automatic logic state_is_busy(state_e s);
        return (s == RUN) || (s == STEP);
    endfunction

endpackage

// File: rtl/exec_controller_sat.sv
// Saturating up-counter: synchronous clear, increment enable, holds at all-ones.
module sat_counter #(
    parameter int NBITS = 32
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [NBITS-1:0] o_count
);

    logic [NBITS-1:0] count_q;
    logic [NBITS-1:0] count_d;

    // Next value: clear dominates, otherwise step unless already saturated.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && (count_q != {NBITS{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        count_q <= count_d;
    end

    assign o_count = count_q;

endmodule

// File: rtl/exec_controller.sv
// Execution controller: turns debug RUN/STEP/ABORT commands into the global
// pipeline enable, stops on a retired HALT and counts enabled cycles.
module exec_controller
    import exec_controller_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    output logic             o_cmd_ready,
    input  logic             i_halt_wb,
    output logic             o_enable,
    output logic             o_step_done,
    output logic             o_halted,
    output logic             o_busy,
    output logic [NBITS-1:0] o_cycles
);

    state_e state_q, state_d;
    logic   enable_q;
    logic   step_done_q;
    logic   halted_q;

    logic   cmd_ready;
    logic   cmd_acc;
    cmd_e   cmd;
    logic   halt_seen;

    // A STEP occupies the pipeline for one cycle and takes no commands then.
    assign cmd_ready = (state_q != STEP);
    assign cmd_acc   = i_cmd_valid && cmd_ready;
    assign cmd       = cmd_e'(i_cmd);
    // HALT is only meaningful while the pipeline is actually advancing.
    assign halt_seen = i_halt_wb && enable_q;

    // Next-state logic; HALT has priority over ABORT in RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    if (cmd == CMD_RUN) begin
                        state_d = RUN;
                    end else if (cmd == CMD_STEP) begin
                        state_d = STEP;
                    end
                end
            end
            RUN: begin
                if (halt_seen) begin
                    state_d = DONE;
                end else if (cmd_acc && (cmd == CMD_ABORT)) begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                state_d = halt_seen ? DONE : IDLE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; outputs are derived from the next state so
    // they line up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            enable_q    <= 1'b0;
            step_done_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            enable_q    <= state_is_busy(state_d);
            step_done_q <= (state_q == STEP);
            halted_q    <= (state_d == DONE);
        end
    end

    // Enabled-cycle counter; reset is its only clear.
    sat_counter #(
        .NBITS (NBITS)
    ) u_cycles (
        .i_clk   (i_clk),
        .i_clr   (i_reset),
        .i_inc   (enable_q),
        .o_count (o_cycles)
    );

    assign o_cmd_ready = cmd_ready;
    assign o_enable    = enable_q;
    assign o_step_done = step_done_q;
    assign o_halted    = halted_q;
    assign o_busy      = state_is_busy(state_q);

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller; a second 4-bit instance covers saturation.
module tb_exec_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        halt;

    logic        ready, en, sdone, halted, busy;
    logic [31:0] cycles;
    logic        ready4, en4, sdone4, halted4, busy4;
    logic [3:0]  cycles4;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] NOP = 2'b00, RUNC = 2'b01, STEPC = 2'b10, ABT = 2'b11;

    always #5 clk = ~clk;

    exec_controller #(.NBITS(32)) dut (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(ready), .i_halt_wb(halt), .o_enable(en),
        .o_step_done(sdone), .o_halted(halted), .o_busy(busy), .o_cycles(cycles)
    );

    exec_controller #(.NBITS(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(ready4), .i_halt_wb(halt), .o_enable(en4),
        .o_step_done(sdone4), .o_halted(halted4), .o_busy(busy4), .o_cycles(cycles4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        tick();
        cmd_valid = 1'b0;
        cmd       = NOP;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".en"},     32'(en),     0);
        chk({tag, ".sdone"},  32'(sdone),  0);
        chk({tag, ".halted"}, 32'(halted), 0);
        chk({tag, ".busy"},   32'(busy),   0);
        chk({tag, ".ready"},  32'(ready),  1);
        chk({tag, ".cycles"}, 32'(cycles), 0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = NOP; halt = 1'b0;

        // Reset then RUN at edge 2, HALT at edge 7.
        tick();                               // edge 1 under reset
        chk_reset_vals("rst");
        rst = 1'b0;
        send(RUNC);                           // edge 2
        chk("run.en3", 32'(en), 1);
        chk("run.busy", 32'(busy), 1);
        chk("run.cyc3", 32'(cycles), 0);
        repeat (4) tick();                    // edges 3..6
        chk("run.cyc6", 32'(cycles), 4);
        halt = 1'b1;
        tick();                               // edge 7
        halt = 1'b0;
        chk("run.en8", 32'(en), 0);
        chk("run.halted", 32'(halted), 1);
        chk("run.cycles", 32'(cycles), 5);
        send(RUNC);                           // discarded in DONE
        chk("done.en", 32'(en), 0);
        chk("done.ready", 32'(ready), 1);
        chk("done.cycles", 32'(cycles), 5);

        // Two STEPs; a command during the STEP cycle is ignored.
        do_reset();
        chk("step.rst.cyc", 32'(cycles), 0);
        send(STEPC);
        chk("step1.en", 32'(en), 1);
        chk("step1.ready", 32'(ready), 0);
        chk("step1.sdone", 32'(sdone), 0);
        send(RUNC);                           // ready=0, must be ignored
        chk("step1.en_off", 32'(en), 0);
        chk("step1.sdone_p", 32'(sdone), 1);
        chk("step1.busy", 32'(busy), 0);
        halt = 1'b1;                          // ignored while disabled
        tick();
        halt = 1'b0;
        chk("step1.sdone_end", 32'(sdone), 0);
        chk("idle.halt_ign", 32'(halted), 0);
        send(STEPC);
        chk("step2.en", 32'(en), 1);
        tick();
        chk("step2.sdone_p", 32'(sdone), 1);
        chk("step2.en_off", 32'(en), 0);
        tick();
        chk("step2.sdone_end", 32'(sdone), 0);
        chk("step2.cycles", 32'(cycles), 2);
        chk("step2.ready", 32'(ready), 1);
        chk("step2.busy", 32'(busy), 0);

        // STEP with HALT in the step cycle.
        do_reset();
        send(STEPC);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("sh.halted", 32'(halted), 1);
        chk("sh.sdone", 32'(sdone), 1);
        chk("sh.en", 32'(en), 0);
        send(RUNC);
        chk("sh.sdone_end", 32'(sdone), 0);
        chk("sh.run_disc", 32'(en), 0);
        chk("sh.busy", 32'(busy), 0);

        // ABORT during RUN, then resume counting.
        do_reset();
        send(RUNC);
        repeat (2) tick();
        chk("ab.cyc", 32'(cycles), 2);
        send(STEPC);                          // discarded in RUN
        chk("ab.step_disc", 32'(en), 1);
        send(ABT);
        chk("ab.en", 32'(en), 0);
        chk("ab.busy", 32'(busy), 0);
        chk("ab.halted", 32'(halted), 0);
        chk("ab.cycles", 32'(cycles), 4);
        tick();
        chk("ab.hold", 32'(cycles), 4);
        send(RUNC);
        repeat (2) tick();
        chk("ab.resume", 32'(cycles), 6);

        // ABORT and HALT at the same edge: HALT wins.
        halt = 1'b1;
        send(ABT);
        halt = 1'b0;
        chk("abh.halted", 32'(halted), 1);
        chk("abh.en", 32'(en), 0);
        chk("abh.cycles", 32'(cycles), 7);

        // Reset mid-RUN.
        do_reset();
        send(RUNC);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk_reset_vals("midrst");
        rst = 1'b0;

        // Saturation on the 4-bit instance.
        send(RUNC);
        repeat (20) tick();
        chk("sat.cyc32", 32'(cycles), 20);
        chk("sat.cyc4", 32'(cycles4), 15);
        repeat (3) tick();
        chk("sat.hold", 32'(cycles4), 15);
        chk("sat.en4", 32'(en4), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_controller.md
# exec_controller

Execution controller for the debug-driven MIPS pipeline. Takes run/step/abort commands from the debug unit and produces the single global enable for the program counter and pipeline registers, so the program counter advances only while this block allows it. Stops execution when the pipeline reports a retired HALT, and keeps a saturating count of enabled cycles for readback.

## Interface

**Parameters**
- `NBITS`, default 32: width of the enabled-cycle counter.

**Ports**
- `i_clk`, in, 1: single clock.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_cmd_valid`, in, 1: command strobe from the debug unit.
- `i_cmd`, in, 2: command code. 00 NOP, 01 RUN, 10 STEP, 11 ABORT.
- `o_cmd_ready`, out, 1: the block can accept a command this cycle.
- `i_halt_wb`, in, 1: a HALT instruction retired in writeback this cycle.
- `o_enable`, out, 1: global enable to the PC and pipeline registers. Registered.
- `o_step_done`, out, 1: one-cycle pulse when a STEP completes.
- `o_halted`, out, 1: sticky flag, set once a HALT has retired.
- `o_busy`, out, 1: high in RUN or STEP.
- `o_cycles`, out, NBITS: number of cycles with `o_enable`=1, saturating.

## Operation

- A command is accepted on a rising edge where `i_cmd_valid` and `o_cmd_ready` are both 1. When `o_cmd_ready`=0, `i_cmd_valid` is ignored. No queueing.
- `o_cmd_ready` is 1 in IDLE, RUN and DONE, and 0 in STEP.

**States**
- **IDLE**: `o_enable`=0.
  - RUN goes to RUN.
  - STEP goes to STEP.
  - NOP and ABORT are accepted and have no effect.
- **RUN**: `o_enable`=1 every cycle.
  - If `i_halt_wb`=1, go to DONE.
  - Else if ABORT is accepted, go to IDLE.
  - RUN, STEP and NOP are accepted and discarded.
- **STEP**: `o_enable`=1 for exactly one cycle.
  - Next state is DONE if `i_halt_wb`=1 in that cycle, else IDLE.
  - `o_step_done` pulses in the cycle after the STEP cycle, in both cases.
- **DONE**: `o_enable`=0, `o_halted`=1.
  - All commands are accepted and discarded.
  - Only `i_reset` leaves DONE.

**Other rules**
- `i_halt_wb` is ignored whenever `o_enable`=0.
- `o_cycles` increments by 1 at each edge where `o_enable`=1, and holds at 2^NBITS−1.
- `o_cycles` is cleared only by `i_reset`.
- `o_busy` = (state==RUN) || (state==STEP).

## Timing

- **Reset values**: state IDLE, `o_enable`=0, `o_step_done`=0, `o_halted`=0, `o_busy`=0, `o_cycles`=0, `o_cmd_ready`=1.
- **Reset priority**: reset overrides everything, including mid-RUN and mid-STEP. `o_enable` is 0 in the cycle after the reset edge.
- **Start latency**: a RUN or STEP accepted at edge k gives `o_enable`=1 from cycle k+1.
- **Stop latency**: `i_halt_wb`=1 sampled at edge k while enabled gives `o_enable`=0 and `o_halted`=1 from cycle k+1. The cycle carrying the HALT is counted in `o_cycles`.
- **Abort latency**: ABORT accepted in RUN at edge k gives `o_enable`=0 from cycle k+1.
- **Simultaneous HALT and ABORT**: if both occur at the same edge in RUN, HALT wins and the state goes to DONE.
- **STEP timing**:
  - `o_enable` is high for exactly one cycle.
  - `o_step_done` is high for exactly one cycle, the cycle right after the STEP cycle.
  - Back-to-back STEPs are therefore at least 2 cycles apart.
- **Counter saturation**: at 2^NBITS−1 the counter holds. There is no wrap and no flag.

## Structure

- **Shared package** holds:
  - Command codes: CMD_NOP, CMD_RUN, CMD_STEP, CMD_ABORT.
  - State encoding: IDLE, RUN, STEP, DONE, 2 bits.
- **Sub-module `sat_counter`** (NBITS, synchronous clear, increment enable, saturation at all-ones) implements `o_cycles`.
- **Top level**: the FSM plus output registers.

## Test plan

- **Reset then RUN**: reset, then RUN at edge 2, `i_halt_wb` at edge 7.
  - `o_enable`=1 for cycles 3..7 and 0 from cycle 8.
  - `o_halted`=1 from cycle 8, `o_cycles`=5.
- **Two STEPs**: STEP, wait, STEP.
  - Two single-cycle `o_enable` pulses and two `o_step_done` pulses, each pulse one cycle after its `o_enable` pulse.
  - `o_cycles`=2, final state IDLE.
- **STEP with `i_halt_wb` in the step cycle**:
  - State DONE, `o_halted`=1, `o_step_done` pulses once.
  - A subsequent RUN is discarded and `o_enable` stays 0.
- **ABORT during RUN**:
  - `o_enable` drops the next cycle, state IDLE, `o_halted`=0.
  - A new RUN resumes counting from the held `o_cycles` value.
- **ABORT and `i_halt_wb` at the same edge**: state DONE, `o_halted`=1.
- **Reset mid-RUN**: all outputs at reset values next cycle.
- **Saturation with NBITS=4**: RUN for 20 cycles, then `o_cycles`=15 and holds.
